// File: rtl/ir_drive_pkg.sv
// Shared types, NEC key codes and frame field helpers for the IR drive commander.
package ir_drive_pkg;

    typedef enum logic [2:0] {
        MOT_STOP  = 3'd0,
        MOT_LEFT  = 3'd1,
        MOT_RIGHT = 3'd2,
        MOT_FWD   = 3'd3,
        MOT_REV   = 3'd4
    } motion_t;

    localparam logic [7:0] KEY_STOP   = 8'h0C;
    localparam logic [7:0] KEY_LEFT   = 8'h14;
    localparam logic [7:0] KEY_RIGHT  = 8'h18;
    localparam logic [7:0] KEY_FWD    = 8'h1C;
    localparam logic [7:0] KEY_REV    = 8'h10;
    localparam logic [7:0] KEY_SPD_UP = 8'h1B;
    localparam logic [7:0] KEY_SPD_DN = 8'h1F;

    function automatic logic [7:0] frame_addr(input logic [31:0] f);
        return f[31:24];
    endfunction

    function automatic logic [7:0] frame_cmd(input logic [31:0] f);
        return f[23:16];
    endfunction

    function automatic logic [7:0] frame_inv(input logic [31:0] f);
        return f[15:8];
    endfunction

endpackage

// File: rtl/ir_drive_commander_watchdog.sv
// No-signal watchdog: counts while enabled, expire is a 1-cycle pulse after CYCLES counts.
// CYCLES=0 disables it (expire held low).
module ir_watchdog #(
    parameter int unsigned CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'((CYCLES == 0) ? 0 : CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expire = (CYCLES != 0) && enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || !enable || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ir_drive_commander.sv
// NEC frame validator and motion/speed controller with no-signal watchdog.
// Optional IR_ERR_COUNT_EN adds a saturating rejected-frame counter (err_count).
//
// state     | meaning
// S_STOP    | motors idle, watchdog held at 0
// S_LEFT    | turning left
// S_RIGHT   | turning right
// S_FWD     | driving forward
// S_REV     | driving in reverse
module ir_drive_commander
    import ir_drive_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned TIMEOUT_MS   = 500,
    parameter int unsigned SPEED_LEVELS = 8,
    parameter int unsigned SPEED_INIT   = 3,
    parameter bit          ADDR_CHECK   = 1'b1,
    parameter logic [7:0]  IR_ADDR      = 8'h00
`ifdef IR_ERR_COUNT_EN
    ,
    parameter int unsigned ERR_W        = 8
`endif
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [31:0]                       ir_data,
    input  logic                              data_ready,
    output logic [2:0]                        state_control,
    output logic [$clog2(SPEED_LEVELS)-1:0]   speed_level,
    output logic                              cmd_valid,
    output logic                              cmd_err,
    output logic                              timeout,
    output logic                              toggle
`ifdef IR_ERR_COUNT_EN
    ,
    output logic [ERR_W-1:0]                  err_count
`endif
);
    localparam int SW = $clog2(SPEED_LEVELS);
    localparam logic [SW-1:0] SPD_MAX  = SW'(SPEED_LEVELS - 1);
    localparam logic [SW-1:0] SPD_INIT = SW'(SPEED_INIT);
    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;

    localparam logic [2:0] S_STOP  = 3'(MOT_STOP);
    localparam logic [2:0] S_LEFT  = 3'(MOT_LEFT);
    localparam logic [2:0] S_RIGHT = 3'(MOT_RIGHT);
    localparam logic [2:0] S_FWD   = 3'(MOT_FWD);
    localparam logic [2:0] S_REV   = 3'(MOT_REV);

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] speed_q, speed_d;
    logic          valid_q, err_q, timeout_q, toggle_q;
    logic          known, accept, wd_expire;
    logic [7:0]    f_cmd;
    logic          addr_ok, inv_ok;

    assign f_cmd   = frame_cmd(ir_data);
    assign addr_ok = !ADDR_CHECK || (frame_addr(ir_data) == IR_ADDR);
    assign inv_ok  = frame_inv(ir_data) == ~f_cmd;

    ir_watchdog #(.CYCLES(TIMEOUT_CYC)) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state_q != S_STOP),
        .clear  (accept),
        .expire (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        known   = 1'b1;
        case (f_cmd)
            KEY_STOP:   state_d = S_STOP;
            KEY_LEFT:   state_d = S_LEFT;
            KEY_RIGHT:  state_d = S_RIGHT;
            // A direct reversal stops first so the drivetrain never flips polarity in one step.
            KEY_FWD:    state_d = (state_q == S_REV) ? S_STOP : S_FWD;
            KEY_REV:    state_d = (state_q == S_FWD) ? S_STOP : S_REV;
            KEY_SPD_UP: if (speed_q != SPD_MAX) speed_d = speed_q + 1'b1;
            KEY_SPD_DN: if (speed_q != '0)      speed_d = speed_q - 1'b1;
            default:    known = 1'b0;
        endcase
        accept = data_ready && addr_ok && inv_ok && known;
        if (!accept) begin
            state_d = state_q;
            speed_d = speed_q;
            if (wd_expire) state_d = S_STOP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_STOP;
            speed_q   <= SPD_INIT;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            speed_q   <= speed_d;
            valid_q   <= accept;
            err_q     <= data_ready && !accept;
            timeout_q <= wd_expire && !accept;
            toggle_q  <= toggle_q ^ accept;
        end
    end

`ifdef IR_ERR_COUNT_EN
    logic [ERR_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (data_ready && !accept && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign state_control = state_q;
    assign speed_level   = speed_q;
    assign cmd_valid     = valid_q;
    assign cmd_err       = err_q;
    assign timeout       = timeout_q;
    assign toggle        = toggle_q;

endmodule

// File: tb/tb_ir_drive_commander.sv
// Scoreboard bench for ir_drive_commander: stimulus queues expected pulses, a monitor checks them.
module tb_ir_drive_commander;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir_data;
    logic        data_ready;
    logic [2:0]  state_control;
    logic [2:0]  speed_level;
    logic        cmd_valid, cmd_err, timeout, toggle;
`ifdef IR_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    always #5 clk = ~clk;

    ir_drive_commander #(
        .CLK_HZ      (1_000_000),
        .TIMEOUT_MS  (1),
        .SPEED_LEVELS(8),
        .SPEED_INIT  (3),
        .ADDR_CHECK  (1'b1),
        .IR_ADDR     (8'h00)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir_data      (ir_data),
        .data_ready   (data_ready),
        .state_control(state_control),
        .speed_level  (speed_level),
        .cmd_valid    (cmd_valid),
        .cmd_err      (cmd_err),
        .timeout      (timeout),
        .toggle       (toggle)
`ifdef IR_ERR_COUNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_ERR   = 3'b010;
    localparam logic [2:0] K_TOUT  = 3'b001;

    localparam logic [31:0] F_STOP  = 32'h000C_F300;
    localparam logic [31:0] F_LEFT  = 32'h0014_EB00;
    localparam logic [31:0] F_RIGHT = 32'h0018_E700;
    localparam logic [31:0] F_FWD   = 32'h001C_E300;
    localparam logic [31:0] F_REV   = 32'h0010_EF00;
    localparam logic [31:0] F_UP    = 32'h001B_E400;
    localparam logic [31:0] F_DN    = 32'h001F_E000;

    typedef struct packed {
        logic [2:0] kind;
        logic [2:0] st;
        logic [2:0] spd;
        logic       tog;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    logic exp_tog = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // {kind, state, speed, toggle} of every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (cmd_valid || cmd_err || timeout) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {22'd0, cmd_valid, cmd_err, timeout, state_control,
                      speed_level, toggle}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse", {22'd0, cmd_valid, cmd_err, timeout, state_control,
                      speed_level, toggle}, {22'd0, e});
            end
        end
    end

    task automatic expect_pulse(input logic [2:0] kind, input logic [2:0] st, input logic [2:0] spd);
        if (kind == K_VALID) exp_tog = ~exp_tog;
        q.push_back({kind, st, spd, exp_tog});
    endtask

    task automatic send(input logic [31:0] f, input logic [2:0] kind,
                        input logic [2:0] st, input logic [2:0] spd);
        expect_pulse(kind, st, spd);
        @(posedge clk);
        #1 ir_data = f;
        data_ready = 1'b1;
        @(posedge clk);
        #1 data_ready = 1'b0;
    endtask

    logic [2:0] up_tab[7];
    logic [2:0] dn_tab[4];

    initial begin
        up_tab = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7};
        dn_tab = '{3'd2, 3'd1, 3'd0, 3'd0};
        rst_n = 1'b0;
        data_ready = 1'b0;
        ir_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_state", {29'd0, state_control}, 32'd0);
        check("reset_speed", {29'd0, speed_level}, 32'd3);
        check("reset_toggle", {31'd0, toggle}, 32'd0);
        check("reset_pulses", {29'd0, cmd_valid, cmd_err, timeout}, 32'd0);

        send(F_LEFT, K_VALID, 3'd1, 3'd3);
        for (int i = 0; i < 7; i++) send(F_UP, K_VALID, 3'd1, up_tab[i]);

        send(F_FWD, K_VALID, 3'd3, 3'd7);
        send(F_REV, K_VALID, 3'd0, 3'd7);
        send(F_REV, K_VALID, 3'd4, 3'd7);

        send(32'h0014_0000, K_ERR, 3'd4, 3'd7);
        send(32'h0514_EB00, K_ERR, 3'd4, 3'd7);
`ifdef IR_ERR_COUNT_EN
        check("err_count", {24'd0, err_count}, 32'd2);
`endif
        send(32'h0055_AA00, K_ERR, 3'd4, 3'd7);
        send(F_REV, K_VALID, 3'd4, 3'd7);
        send(F_STOP, K_VALID, 3'd0, 3'd7);
        send(F_RIGHT, K_VALID, 3'd2, 3'd7);

        // Accepting edge is A; expiry lands on edge A+1000.
        send(F_LEFT, K_VALID, 3'd1, 3'd7);
        expect_pulse(K_TOUT, 3'd0, 3'd7);
        repeat (999) @(posedge clk);
        #1 check("pre_expiry_state", {29'd0, state_control}, 32'd1);
        check("pre_expiry_pulse", {31'd0, timeout}, 32'd0);
        @(posedge clk);
        #1 check("post_expiry_state", {29'd0, state_control}, 32'd0);
        repeat (1100) @(posedge clk);
        #1 check("stop_holds", {29'd0, state_control}, 32'd0);

        send(F_LEFT, K_VALID, 3'd1, 3'd7);
        repeat (998) @(posedge clk);
        send(F_LEFT, K_VALID, 3'd1, 3'd7);
        check("frame_beats_expiry", {29'd0, state_control}, 32'd1);

        send(F_RIGHT, K_VALID, 3'd2, 3'd7);
        @(posedge clk);
        #1 rst_n = 1'b0;
        ir_data = F_LEFT;
        data_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        data_ready = 1'b0;
        exp_tog = 1'b0;
        check("midrun_reset_state", {29'd0, state_control}, 32'd0);
        check("midrun_reset_speed", {29'd0, speed_level}, 32'd3);
        check("midrun_reset_toggle", {31'd0, toggle}, 32'd0);
        check("midrun_reset_valid", {31'd0, cmd_valid}, 32'd0);
`ifdef IR_ERR_COUNT_EN
        check("err_count_reset", {24'd0, err_count}, 32'd0);
`endif

        for (int i = 0; i < 4; i++) send(F_DN, K_VALID, 3'd0, dn_tab[i]);

        repeat (5) @(posedge clk);
        #1 check("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
